// File: rtl/key_pio_rx.sv
// Debounced key input port with an Avalon-MM slave: DATA / IRQMASK / EDGECAP registers and a level irq.
// Optional macro KEY_PIO_BOTH_EDGES_EN: EDGECAP also captures release (1->0) edges of the debounced keys.
module key_pio_rx #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_chipselect,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RELEASED = {WIDTH{ACTIVE_LOW}};

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] pressed;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_set, edge_clr;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_en, rd_en;
  logic             unused_wdata;

  assign unused_wdata = ^avs_writedata;
  assign pressed      = ACTIVE_LOW ? ~sync_q : sync_q;
  assign wr_en        = avs_chipselect & avs_write;
  assign rd_en        = avs_chipselect & avs_read;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      // Commit on the cycle the count would reach DEBOUNCE_CYCLES.
      if (pressed[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = pressed[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end

`ifdef KEY_PIO_BOTH_EDGES_EN
    edge_set = (deb_d & ~deb_q) | (~deb_d & deb_q);
`else
    edge_set = deb_d & ~deb_q;
`endif

    edge_clr = (wr_en && avs_address == 2'd2) ? avs_writedata[WIDTH-1:0] : '0;
    edge_d   = (edge_q & ~edge_clr) | edge_set;
    mask_d   = (wr_en && avs_address == 2'd1) ? avs_writedata[WIDTH-1:0] : mask_q;
    irq_d    = |(edge_q & mask_q);

    // Reads see pre-write register contents.
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (avs_address)
        2'd0:    rdata_d[WIDTH-1:0] = deb_q;
        2'd1:    rdata_d[WIDTH-1:0] = mask_q;
        2'd2:    rdata_d[WIDTH-1:0] = edge_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= RELEASED;
      sync_q  <= RELEASED;
      deb_q   <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q  <= key_in;
      sync_q  <= meta_q;
      deb_q   <= deb_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_key_pio_rx.sv
// Directed bench for key_pio_rx (WIDTH=4, DEBOUNCE_CYCLES=16, ACTIVE_LOW=1).
module tb_key_pio_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  key_in;
  logic [1:0]  avs_address;
  logic        avs_chipselect, avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  key_pio_rx #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in),
    .avs_address(avs_address), .avs_chipselect(avs_chipselect),
    .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_write = 1'b0; avs_writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    @(posedge clk); #1;
    d = avs_readdata;
    avs_chipselect = 1'b0; avs_read = 1'b0;
  endtask

  // Reads DATA every cycle; returns the first cycle (1-based) it equals val, or -1.
  task automatic wait_data(input logic [31:0] val, input int maxc, output int n);
    n = -1;
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 2'd0;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk); #1;
      if (n < 0 && avs_readdata == val) n = i;
    end
    avs_chipselect = 1'b0; avs_read = 1'b0;
  endtask

  task automatic wait_irq(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk); #1;
      if (n < 0 && irq) n = i;
    end
  endtask

  logic [31:0] rd;
  int          n;

  initial begin
    reset_n = 1'b0; key_in = 4'hF;
    avs_address = '0; avs_chipselect = 1'b0; avs_read = 1'b0;
    avs_write = 1'b0; avs_writedata = '0;
    idle(3);
    check("reset_readdata", avs_readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    idle(2);

    bus_read(2'd0, rd); check("init_data", rd, 32'h0);
    bus_read(2'd1, rd); check("init_mask", rd, 32'h0);
    bus_read(2'd2, rd); check("init_edgecap", rd, 32'h0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd3, rd); check("addr3_reads0", rd, 32'h0);
    bus_read(2'd0, rd); check("data_ro", rd, 32'h0);

    // Simultaneous read and write: read returns old value, upper bits read 0.
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b1;
    avs_address = 2'd1; avs_writedata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    check("rw_same_cycle_old", avs_readdata, 32'h0);
    bus_read(2'd1, rd); check("mask_width", rd, 32'hF);
    check("readdata_hold", avs_readdata, 32'hF);
    bus_write(2'd1, 32'h0);

    // Press key 0: 2 sync + 16 debounce + 1 read latency.
    key_in = 4'hE;
    wait_data(32'h1, 30, n);
    check("press_latency", n, 32'd19);
    bus_read(2'd2, rd); check("press_edgecap", rd, 32'h1);
    check("irq_masked", {31'b0, irq}, 32'h0);
    key_in = 4'hF;
    idle(30);
    bus_read(2'd0, rd); check("release_data", rd, 32'h0);
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd); check("w1c_edgecap", rd, 32'h0);

    // Glitch shorter than the debounce window.
    key_in = 4'hD; idle(10);
    key_in = 4'hF; idle(30);
    bus_read(2'd0, rd); check("glitch_data", rd, 32'h0);
    bus_read(2'd2, rd); check("glitch_edgecap", rd, 32'h0);

    // irq path.
    bus_write(2'd1, 32'h1);
    key_in = 4'hE;
    wait_irq(40, n);
    check("irq_latency", n, 32'd19);
    bus_read(2'd2, rd); check("irq_edgecap", rd, 32'h1);
    bus_write(2'd2, 32'h1);
    check("irq_after_clear_edge", {31'b0, irq}, 32'h1);
    idle(1);
    check("irq_cleared", {31'b0, irq}, 32'h0);
    bus_read(2'd2, rd); check("irq_edgecap_clr", rd, 32'h0);
    key_in = 4'hF; idle(30);
`ifdef KEY_PIO_BOTH_EDGES_EN
    check("release_irq", {31'b0, irq}, 32'h1);
`else
    check("release_irq", {31'b0, irq}, 32'h0);
`endif
    bus_write(2'd2, 32'hF);
    bus_write(2'd1, 32'h0);
    idle(2);

    // Clear coinciding with the debounced press: set wins.
    key_in = 4'hE;
    idle(17);
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd); check("set_beats_clear", rd, 32'h1);
    key_in = 4'hF; idle(30);
    bus_write(2'd2, 32'hF);

    // Key 2 press then release.
    key_in = 4'hB; idle(30);
    bus_read(2'd2, rd); check("key2_press", rd, 32'h4);
    bus_write(2'd2, 32'h4);
    bus_read(2'd2, rd); check("key2_clr", rd, 32'h0);
    key_in = 4'hF; idle(30);
    bus_read(2'd2, rd);
`ifdef KEY_PIO_BOTH_EDGES_EN
    check("key2_release", rd, 32'h4);
`else
    check("key2_release", rd, 32'h0);
`endif
    bus_write(2'd2, 32'hF);

    // Reset in the middle of a debounce (count = 8).
    bus_write(2'd1, 32'hF);
    key_in = 4'h7;
    idle(10);
    reset_n = 1'b0;
    #1;
    check("midreset_readdata", avs_readdata, 32'h0);
    check("midreset_irq", {31'b0, irq}, 32'h0);
    idle(3);
    reset_n = 1'b1;
    wait_data(32'h8, 30, n);
    check("restart_latency", n, 32'd19);
    bus_read(2'd1, rd); check("reset_mask", rd, 32'h0);
    bus_read(2'd2, rd); check("restart_edgecap", rd, 32'h8);
    check("restart_irq_masked", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
